// File: rtl/gen12_lane_scrambler.sv
// Gen1/Gen2 PCIe per-lane scrambler with integrated Galois LFSR and one registered valid/ready output stage.
// Optional COM counter output com_cnt_o enabled by defining GEN12_SCR_COM_CNT_EN.
module gen12_lane_scrambler #(
  parameter int          BYTES = 4,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [8*BYTES-1:0] data_i,
  input  logic [BYTES-1:0]   datak_i,
  input  logic [BYTES-1:0]   ts_i,
  input  logic               scramble_en_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [8*BYTES-1:0] data_o,
  output logic [BYTES-1:0]   datak_o,
  output logic               valid_o,
  input  logic               ready_i,
`ifdef GEN12_SCR_COM_CNT_EN
  output logic [15:0]        com_cnt_o,
`endif
  output logic [15:0]        lfsr_o
);

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;

  logic [8*BYTES-1:0] r_data;
  logic [BYTES-1:0]   r_datak;
  logic               r_valid;
  logic [15:0]        r_lfsr;

  logic               w_accept;
  logic [8*BYTES-1:0] w_data;
  logic [15:0]        w_lfsrNext;
  logic [3:0]         w_comCount;

  // Eight Galois steps: returns {scramble byte, next state}; first out bit lands in key bit 0.
  function automatic logic [23:0] advance8(input logic [15:0] state);
    logic [15:0] v;
    logic [7:0]  k;
    v = state;
    k = '0;
    for (int b = 0; b < 8; b++) begin
      k[b] = v[15];
      v    = {v[14:0], 1'b0} ^ (v[15] ? 16'h0039 : 16'h0000);
    end
    return {k, v};
  endfunction

  assign ready_o  = ~r_valid | ready_i;
  assign w_accept = valid_i & ready_o;

  // Symbols are walked in time order so the LFSR chains through the whole beat.
  always_comb begin : scrambleBeat
    logic [15:0] s;
    logic [23:0] adv;
    logic [7:0]  sym;
    s          = r_lfsr;
    adv        = '0;
    sym        = '0;
    w_data     = '0;
    w_comCount = '0;
    for (int i = 0; i < BYTES; i++) begin
      sym = data_i[8*i +: 8];
      adv = advance8(s);
      if (datak_i[i] && sym == COM_SYM) begin
        w_data[8*i +: 8] = sym;
        s                = SEED;
        w_comCount       = w_comCount + 4'd1;
      end else if (datak_i[i] && sym == SKP_SYM) begin
        w_data[8*i +: 8] = sym;
      end else begin
        if (!datak_i[i] && !ts_i[i] && scramble_en_i)
          w_data[8*i +: 8] = sym ^ adv[23:16];
        else
          w_data[8*i +: 8] = sym;
        s = adv[15:0];
      end
    end
    w_lfsrNext = s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_datak <= '0;
      r_valid <= 1'b0;
      r_lfsr  <= SEED;
    end else if (w_accept) begin
      r_data  <= w_data;
      r_datak <= datak_i;
      r_valid <= 1'b1;
      r_lfsr  <= w_lfsrNext;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

`ifdef GEN12_SCR_COM_CNT_EN
  logic [15:0] r_comCnt;
  logic [16:0] w_comSum;

  assign w_comSum = {1'b0, r_comCnt} + {13'd0, w_comCount};

  // Saturating count of COM symbols across accepted beats.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_comCnt <= '0;
    else if (w_accept)
      r_comCnt <= w_comSum[16] ? 16'hFFFF : w_comSum[15:0];
  end

  assign com_cnt_o = r_comCnt;
`endif

  assign data_o  = r_data;
  assign datak_o = r_datak;
  assign valid_o = r_valid;
  assign lfsr_o  = r_lfsr;

endmodule

// File: tb/tb_gen12_lane_scrambler.sv
// Self-checking bench for gen12_lane_scrambler (BYTES=4): directed test-plan beats, then randomized
// traffic against a keystream-index reference model.
module tb_gen12_lane_scrambler;

  localparam int BYTES = 4;
  localparam int KS_N  = 8192;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] data_i = '0;
  logic [3:0]  datak_i = '0;
  logic [3:0]  ts_i = '0;
  logic        scramble_en_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_o;
  logic [3:0]  datak_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [15:0] lfsr_o;
`ifdef GEN12_SCR_COM_CNT_EN
  logic [15:0] com_cnt_o;
`endif

  gen12_lane_scrambler #(.BYTES(BYTES), .SEED(16'hFFFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .datak_i(datak_i), .ts_i(ts_i),
    .scramble_en_i(scramble_en_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .datak_o(datak_o), .valid_o(valid_o), .ready_i(ready_i),
`ifdef GEN12_SCR_COM_CNT_EN
    .com_cnt_o(com_cnt_o),
`endif
    .lfsr_o(lfsr_o)
  );

  always #5 clk_i = ~clk_i;

  int testsRun  = 0;
  int testsFail = 0;

  // Reference: keystream byte n and LFSR state after n scrambling bytes from SEED.
  logic [7:0]  ks [KS_N];
  logic [15:0] st [KS_N+1];
  int          expIdx;
  logic [31:0] expData;
  logic [3:0]  expK;
  logic        expValid;
  int          expComCnt;

  task automatic buildKeystream();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int n = 0; n < KS_N; n++) begin
      st[n] = s;
      for (int b = 0; b < 8; b++) begin
        ks[n][b] = s[15];
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
      end
    end
    st[KS_N] = s;
  endtask

  task automatic modelReset();
    expIdx    = 0;
    expData   = '0;
    expK      = '0;
    expValid  = 1'b0;
    expComCnt = 0;
  endtask

  task automatic modelAccept(input logic [31:0] d, input logic [3:0] k,
                             input logic [3:0] ts, input logic en);
    logic [7:0] sym;
    for (int i = 0; i < BYTES; i++) begin
      sym = d[8*i +: 8];
      if (k[i] && sym == 8'hBC) begin
        expData[8*i +: 8] = sym;
        expIdx = 0;
        if (expComCnt < 65535) expComCnt++;
      end else if (k[i] && sym == 8'h1C) begin
        expData[8*i +: 8] = sym;
      end else begin
        expData[8*i +: 8] = (!k[i] && !ts[i] && en) ? (sym ^ ks[expIdx]) : sym;
        expIdx++;
      end
    end
    expK     = k;
    expValid = 1'b1;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, ".valid"}, {31'd0, valid_o}, {31'd0, expValid});
    checkEq({tag, ".ready"}, {31'd0, ready_o}, {31'd0, (~expValid | ready_i)});
    checkEq({tag, ".data"},  data_o, expData);
    checkEq({tag, ".datak"}, {28'd0, datak_o}, {28'd0, expK});
    checkEq({tag, ".lfsr"},  {16'd0, lfsr_o}, {16'd0, st[expIdx]});
`ifdef GEN12_SCR_COM_CNT_EN
    checkEq({tag, ".comcnt"}, {16'd0, com_cnt_o}, expComCnt);
`endif
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks just after it.
  task automatic applyStimulus(input string tag, input logic v, input logic [31:0] d,
                               input logic [3:0] k, input logic [3:0] ts,
                               input logic en, input logic rdy);
    valid_i = v; data_i = d; datak_i = k; ts_i = ts; scramble_en_i = en; ready_i = rdy;
    if (v && (!expValid || rdy)) modelAccept(d, k, ts, en);
    else if (rdy) expValid = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput(tag);
  endtask

  function automatic logic [7:0] randSym(input logic isK);
    int r;
    r = $urandom_range(0, 3);
    if (!isK) return 8'($urandom);
    case (r)
      0: return 8'hBC;
      1: return 8'h1C;
      2: return 8'hFB;
      default: return 8'hF7;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    logic [31:0] d;
    logic [3:0]  k;

    buildKeystream();
    modelReset();

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset");
    rst_i = 1'b0;

    applyStimulus("zero0", 1'b1, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    checkEq("zero0.const", data_o, 32'h14C017FF);
    applyStimulus("zero1", 1'b1, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    checkEq("zero1.const", data_o, 32'h8202E7B2);

    applyStimulus("com", 1'b1, 32'h000000BC, 4'h1, 4'h0, 1'b1, 1'b1);
    checkEq("com.const", data_o, 32'hC017FFBC);

    applyStimulus("comskp", 1'b1, 32'h00001CBC, 4'h3, 4'h0, 1'b1, 1'b1);
    checkEq("comskp.const", data_o, 32'h17FF1CBC);

    applyStimulus("com4", 1'b1, 32'hBCBCBCBC, 4'hF, 4'h0, 1'b1, 1'b1);
    applyStimulus("ts", 1'b1, 32'h0, 4'h0, 4'hF, 1'b1, 1'b1);
    checkEq("ts.const", data_o, 32'h0);
    applyStimulus("afterTs", 1'b1, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    checkEq("afterTs.const", data_o, 32'h8202E7B2);

    applyStimulus("bpLoad", 1'b1, 32'h12345678, 4'h0, 4'h0, 1'b1, 1'b0);
    held = expData;
    for (int c = 0; c < 3; c++) begin
      applyStimulus("bpHold", 1'b1, $urandom, 4'h0, 4'h0, 1'b1, 1'b0);
      checkEq("bpHold.stable", data_o, held);
    end
    for (int c = 0; c < 4; c++)
      applyStimulus("bpRelease", 1'b1, $urandom, 4'h0, 4'h0, 1'b1, 1'b1);

    for (int c = 0; c < 400; c++) begin
      d = '0;
      k = '0;
      for (int i = 0; i < BYTES; i++) begin
        k[i] = ($urandom_range(0, 5) == 0);
        d[8*i +: 8] = randSym(k[i]);
      end
      applyStimulus("rand", ($urandom_range(0, 3) != 0), d, k, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0));
    end

    applyStimulus("preRst", 1'b1, 32'hA5A5A5A5, 4'h0, 4'h0, 1'b1, 1'b0);
    valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    modelReset();
    checkEq("midRst.valid", {31'd0, valid_o}, 32'd0);
    checkEq("midRst.lfsr", {16'd0, lfsr_o}, 32'h0000FFFF);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    applyStimulus("postRst", 1'b1, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    checkEq("postRst.const", data_o, 32'h14C017FF);
    applyStimulus("drain", 1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule

// File: doc/gen12_lane_scrambler.md
Name: gen12_lane_scrambler

Overview:
- Per-lane 8b/10b-era (Gen1/Gen2) PCIe scrambler with the LFSR integrated.
- Processes BYTES symbols per cycle and applies the full symbol rules: COM resets the LFSR, SKP freezes it, other K symbols and training-sequence data pass through unscrambled.
- Sits between the lane's TX symbol mux and the 8b/10b encoder.
- Has one registered output stage with a valid/ready handshake.

Parameters:
- BYTES, 4, symbols per beat; legal values 1, 2, 4, 8. Symbol 0 occupies bits [7:0] and is first in time.
- SEED, 16'hFFFF, LFSR value loaded at reset and after every COM.

Ports:
- clk_i  input  1  lane clock
- rst_i  input  1  asynchronous, active-high reset
- data_i  input  8*BYTES  raw symbols
- datak_i  input  BYTES  per-symbol K flag
- ts_i  input  BYTES  per-symbol training-sequence data flag
- scramble_en_i  input  1  0 = bypass; LFSR still advances
- valid_i  input  1  input beat valid
- ready_o  output  1  input beat accepted when valid_i & ready_o
- data_o  output  8*BYTES  scrambled symbols
- datak_o  output  BYTES  registered copy of datak_i
- valid_o  output  1  output beat valid
- ready_i  input  1  downstream ready
- lfsr_o  output  16  LFSR state after the last accepted beat (debug)

Behaviour:
- Reset (async assert, sync release):
  - lfsr = SEED.
  - data_o = 0, datak_o = 0, valid_o = 0, lfsr_o = SEED.
  - ready_o = 1 after reset.
- LFSR: Galois form of G(x) = x^16 + x^5 + x^4 + x^3 + 1.
  - One step: out = lfsr[15]; lfsr = {lfsr[14:0], 0} ^ (out ? 16'h0039 : 0).
  - Scramble byte for a symbol = 8 successive out bits; the first bit goes to data bit 0.
- Symbols are processed sequentially within a beat, symbol 0 first. The LFSR state chains combinationally across the BYTES symbols.
- Per-symbol rules, in priority order:
  1. K=1, byte 8'hBC (COM): output unscrambled; LFSR loads SEED after this symbol.
  2. K=1, byte 8'h1C (SKP): output unscrambled; LFSR unchanged.
  3. Any other K=1 symbol: output unscrambled; LFSR advances 8 steps.
  4. K=0 and ts_i=1: output unscrambled; LFSR advances 8 steps.
  5. K=0, ts_i=0, scramble_en_i=1: output = data ^ scramble byte; LFSR advances 8 steps.
  6. K=0, ts_i=0, scramble_en_i=0: output unscrambled; LFSR advances 8 steps.
- Handshake:
  - ready_o = ~valid_o | ready_i (combinational).
  - On accept: the output register loads the processed beat, valid_o = 1, lfsr and lfsr_o update.
  - If ready_i=1 and nothing is accepted: valid_o → 0.
  - valid_o=1 & ready_i=0: data_o, datak_o and valid_o are held stable; the LFSR does not advance.
  - Simultaneous output drain and input accept: the new beat is loaded in the same cycle, so throughput is 1 beat/cycle.
- Latency: 1 cycle from accept to valid_o.
- Cycles with valid_i=0 do not advance the LFSR.
- Multiple COMs in one beat: each COM reseeds; symbols after the last COM use the sequence from SEED.
- Reset mid-stream: the in-flight output beat is dropped and the LFSR is reseeded.

Optional Feature:
- Macro: GEN12_SCR_COM_CNT_EN.
- Defined:
  - Adds output com_cnt_o [15:0]: the number of COM symbols accepted.
  - Saturates at 16'hFFFF; reset value 0.
  - Incremented by the count of COMs in the accepted beat (popcount, up to BYTES).
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- BYTES=4, reset, scramble_en=1, ready_i=1, two beats of 32'h00000000, no K → data_o = 32'h14C017FF, then 32'h8202E7B2; lfsr_o is nonzero and changes each beat.
- Beat {D,D,D,COM} (symbol 0 = 8'hBC, K) followed by zero data → COM byte passes as BC with datak_o[0]=1; the next bytes are FF, 17, C0 (sequence restarts).
- Beat with SKP (1C, K) in symbol 1 between zero-data symbols → symbol 2 uses the scramble byte that symbol 1 would have used; SKP outputs 1C.
- ts_i=4'hF on zero data → data_o = 0; the following beat's scramble bytes equal 4 bytes further along the sequence (B2, E7, 02, 82).
- Backpressure: ready_i=0 for 3 cycles with valid_i=1 → ready_o=0, data_o stable, lfsr_o unchanged. Releasing ready_i gives one accept per cycle with no data loss.
- Assert rst_i mid-stream with valid_o=1 → valid_o=0 immediately and lfsr_o=16'hFFFF. First beat after release outputs FF, 17, C0, 14 on zero data.
